// File: rtl/core_run_controller.sv
// core_run_controller
//   Sequences execution of the core: owns the core/counter enable and offers
//   free run, N-cycle step and single PC breakpoint with step-past-on-resume.
//
//   Ports
//     clk, rst      core clock, asynchronous active-high reset
//     resume        raw resume button level (asynchronous to clk)
//     step_mode     1: resume starts an N-cycle step, 0: resume starts free run
//     step_count    N for step mode, sampled only on an accepted resume pulse
//     bp_en, bp_pc  breakpoint enable and address
//     pc            current core PC
//     halt          core halt request (syscall), combinational
//     en            core / counter enable, combinational
//     state         0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//     stop_cause    0 NONE, 1 SYSCALL, 2 BREAKPOINT, 3 STEP_DONE
//     run_cycles    saturating count of cycles with en=1
module core_run_controller #(
    parameter int PcBit   = 32,
    parameter int StepBit = 16,
    parameter int CycBit  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               resume,
    input  logic               step_mode,
    input  logic [StepBit-1:0] step_count,
    input  logic               bp_en,
    input  logic [PcBit-1:0]   bp_pc,
    input  logic [PcBit-1:0]   pc,
    input  logic               halt,
    output logic               en,
    output logic [1:0]         state,
    output logic [1:0]         stop_cause,
    output logic [CycBit-1:0]  run_cycles
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'd0;
    localparam logic [1:0] CAUSE_SYSCALL   = 2'd1;
    localparam logic [1:0] CAUSE_BREAKPT   = 2'd2;
    localparam logic [1:0] CAUSE_STEP_DONE = 2'd3;

    localparam logic [StepBit-1:0] STEP_ONE = {{(StepBit-1){1'b0}}, 1'b1};
    localparam logic [CycBit-1:0]  CYC_ONE  = {{(CycBit-1){1'b0}}, 1'b1};

    function automatic logic [CycBit-1:0] sat_inc(input logic [CycBit-1:0] v);
        return (&v) ? v : v + CYC_ONE;
    endfunction

    state_t             cur_state;
    logic [1:0]         cause;
    logic [StepBit-1:0] step_cnt;
    logic               bp_skip;
    logic [CycBit-1:0]  cyc_cnt;
    logic               res_p0, res_p1, res_p2;
    logic               res_pulse;
    logic               bp_hit;
    logic               stop;
    logic               resume_bp;

    // resume synchroniser: two flops for metastability, third for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p0 <= 1'b0;
            res_p1 <= 1'b0;
            res_p2 <= 1'b0;
        end else begin
            res_p0 <= resume;
            res_p1 <= res_p0;
            res_p2 <= res_p1;
        end
    end

    assign res_pulse = res_p1 & ~res_p2;

    // bp_skip suppresses the breakpoint that caused the halt so resume can
    // execute that instruction once; it re-arms on the first enabled cycle.
    assign bp_hit    = bp_en && (pc == bp_pc) && !bp_skip;
    assign stop      = halt || bp_hit;
    assign en        = ((cur_state == RUN) || (cur_state == STEP)) && !stop;
    assign resume_bp = (cur_state == HALTED) && (cause == CAUSE_BREAKPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            cause     <= CAUSE_NONE;
            step_cnt  <= '0;
            bp_skip   <= 1'b0;
        end else begin
            case (cur_state)
                IDLE, HALTED: begin
                    if (res_pulse) begin
                        if (!step_mode) begin
                            cur_state <= RUN;
                            cause     <= CAUSE_NONE;
                            bp_skip   <= resume_bp;
                        end else if (step_count != '0) begin
                            cur_state <= STEP;
                            cause     <= CAUSE_NONE;
                            step_cnt  <= step_count;
                            bp_skip   <= resume_bp;
                        end
                    end
                end
                RUN: begin
                    if (halt) begin
                        cur_state <= HALTED;
                        cause     <= CAUSE_SYSCALL;
                    end else if (bp_hit) begin
                        cur_state <= HALTED;
                        cause     <= CAUSE_BREAKPT;
                    end else begin
                        bp_skip <= 1'b0;
                    end
                end
                STEP: begin
                    if (halt) begin
                        cur_state <= HALTED;
                        cause     <= CAUSE_SYSCALL;
                    end else if (bp_hit) begin
                        cur_state <= HALTED;
                        cause     <= CAUSE_BREAKPT;
                    end else begin
                        bp_skip  <= 1'b0;
                        step_cnt <= step_cnt - STEP_ONE;
                        if (step_cnt == STEP_ONE) begin
                            cur_state <= HALTED;
                            cause     <= CAUSE_STEP_DONE;
                        end
                    end
                end
                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (en) begin
            cyc_cnt <= sat_inc(cyc_cnt);
        end
    end

    assign state      = cur_state;
    assign stop_cause = cause;
    assign run_cycles = cyc_cnt;

endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller
//   Directed bench for core_run_controller. Two instances share all inputs:
//   a 32-bit run counter and a 4-bit one for saturation. A behavioural model
//   derives the expected outputs from the resume history and the run/step/
//   breakpoint rules; a negedge process compares every cycle, and literal
//   checks pin key points of each scenario.
module tb_core_run_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resume = 1'b0;
    logic        step_mode = 1'b0;
    logic [15:0] step_count = '0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = '0;
    logic [31:0] pc = '0;
    logic        halt = 1'b0;

    logic        en, en4;
    logic [1:0]  state, state4;
    logic [1:0]  stop_cause, cause4;
    logic [31:0] run_cycles;
    logic [3:0]  cyc4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_run_controller #(.PcBit(32), .StepBit(16), .CycBit(32)) dut (
        .clk(clk), .rst(rst), .resume(resume), .step_mode(step_mode),
        .step_count(step_count), .bp_en(bp_en), .bp_pc(bp_pc), .pc(pc),
        .halt(halt), .en(en), .state(state), .stop_cause(stop_cause),
        .run_cycles(run_cycles)
    );

    core_run_controller #(.PcBit(32), .StepBit(16), .CycBit(4)) dut4 (
        .clk(clk), .rst(rst), .resume(resume), .step_mode(step_mode),
        .step_count(step_count), .bp_en(bp_en), .bp_pc(bp_pc), .pc(pc),
        .halt(halt), .en(en4), .state(state4), .stop_cause(cause4),
        .run_cycles(cyc4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 run, 2 step, 3 halted
    int     m_mode;
    int     m_left;
    bit     m_skip;
    int     m_cause;
    longint m_cyc;
    bit     rh[$];   // resume levels seen at past edges, newest first

    function automatic bit m_bphit();
        return bp_en && (pc == bp_pc) && !m_skip;
    endfunction

    function automatic bit m_en();
        return ((m_mode == 1) || (m_mode == 2)) && !halt && !m_bphit();
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit pulse;
        bit e;
        bit bh;
        bit from_bp;
        if (rst) begin
            m_mode = 0; m_left = 0; m_skip = 0; m_cause = 0; m_cyc = 0;
            rh.delete();
        end else begin
            // accepted press: high two edges ago, low three edges ago
            pulse = (rh.size() > 1 && rh[1]) && !(rh.size() > 2 && rh[2]);
            e  = m_en();
            bh = m_bphit();
            rh.push_front(resume);
            if (rh.size() > 3) void'(rh.pop_back());
            if (m_mode == 0 || m_mode == 3) begin
                from_bp = (m_mode == 3) && (m_cause == 2);
                if (pulse && !step_mode) begin
                    m_mode = 1; m_cause = 0; m_skip = from_bp;
                end else if (pulse && step_count != 0) begin
                    m_mode = 2; m_cause = 0; m_skip = from_bp; m_left = int'(step_count);
                end
            end else if (halt) begin
                m_mode = 3; m_cause = 1;
            end else if (bh) begin
                m_mode = 3; m_cause = 2;
            end else if (e) begin
                m_cyc++;
                m_skip = 0;
                if (m_mode == 2) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 3; m_cause = 3;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("en", en, m_en());
            chk("state", state, m_mode);
            chk("stop_cause", stop_cause, m_cause);
            chk("run_cycles", run_cycles, (m_cyc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cyc);
            chk("en4", en4, m_en());
            chk("state4", state4, m_mode);
            chk("run_cycles4", cyc4, (m_cyc > 15) ? 15 : m_cyc);
        end
    end

    // ---------------- stimulus ----------------
    // one clock: sample en mid-cycle, advance pc after the edge if enabled
    task automatic tick(input int n);
        logic e;
        repeat (n) begin
            @(negedge clk);
            e = en;
            @(posedge clk);
            #1;
            if (e) pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        resume = 1'b0;
        halt = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_en", en, 0);
        chk("rst_cycles", run_cycles, 0);
        chk("rst_cycles4", cyc4, 0);
        @(posedge clk);
        #1;
        pc = '0;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        tick(2);
        rst = 1'b0;

        // free run: state changes on the third edge after resume rises
        resume = 1'b1;
        tick(2);
        chk("run_not_yet", state, 0);
        tick(1);
        chk("run_entered", state, 1);
        tick(10);
        chk("run_count10", run_cycles, 10);
        resume = 1'b0;
        tick(3);
        resume = 1'b1;
        tick(4);
        chk("resume_in_run", state, 1);
        do_reset();

        // step mode: zero count ignored, then five enabled cycles
        step_mode = 1'b1;
        step_count = 16'd0;
        resume = 1'b1;
        tick(4);
        resume = 1'b0;
        tick(3);
        chk("step0_idle", state, 0);
        step_count = 16'd5;
        resume = 1'b1;
        tick(3);
        step_count = 16'd9;
        tick(1);
        resume = 1'b0;
        tick(10);
        chk("step5_state", state, 3);
        chk("step5_cause", stop_cause, 3);
        chk("step5_cycles", run_cycles, 5);
        do_reset();

        // breakpoint at 0x10, resume steps past it, next visit halts again
        step_mode = 1'b0;
        bp_en = 1'b1;
        bp_pc = 32'h10;
        resume = 1'b1;
        tick(3);
        resume = 1'b0;
        tick(6);
        chk("bp_state", state, 3);
        chk("bp_cause", stop_cause, 2);
        chk("bp_pc", pc, 32'h10);
        chk("bp_en_low", en, 0);
        chk("bp_cycles", run_cycles, 4);
        resume = 1'b1;
        tick(3);
        resume = 1'b0;
        chk("bp_resume_en", en, 1);
        tick(1);
        chk("bp_past_pc", pc, 32'h14);
        pc = 32'h8;
        tick(6);
        chk("bp_again_state", state, 3);
        chk("bp_again_cause", stop_cause, 2);
        chk("bp_again_pc", pc, 32'h10);
        do_reset();

        // halt and breakpoint together: syscall wins, en never asserted
        bp_en = 1'b1;
        bp_pc = 32'h10;
        pc = 32'h10;
        halt = 1'b1;
        resume = 1'b1;
        tick(5);
        resume = 1'b0;
        tick(2);
        chk("both_state", state, 3);
        chk("both_cause", stop_cause, 1);
        chk("both_en", en, 0);
        chk("both_cycles", run_cycles, 0);
        // bouncing resume in HALTED with halt held
        for (int i = 0; i < 12; i++) begin
            resume = ~resume;
            tick(1);
        end
        resume = 1'b0;
        tick(4);
        chk("bounce_cycles", run_cycles, 0);
        halt = 1'b0;
        bp_en = 1'b0;
        do_reset();

        // held resume: one transition; 4-bit counter saturates
        resume = 1'b1;
        tick(100);
        chk("held_state", state, 1);
        chk("held_cycles", run_cycles, 97);
        chk("sat4", cyc4, 4'hF);
        resume = 1'b0;
        tick(2);
        resume = 1'b1;
        tick(5);
        chk("held_state2", state, 1);
        chk("sat4_hold", cyc4, 4'hF);
        resume = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
